// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared types, note table and half-period helper for beep_gen
package beep_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // C4 D4 E4 F4 G4 A4 B4 C5, indexed by the 3-bit tone select
  localparam int unsigned NOTE_HZ [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

  function automatic int unsigned hp_of(input int unsigned clk_hz, input int unsigned idx);
    return clk_hz / (2 * NOTE_HZ[idx]);
  endfunction

endpackage

// File: rtl/beep_gen_if.sv
// rtl/beep_gen_if.sv - trigger/tone request and piezo/status response bundle
interface beep_gen_if;
  logic       trig;
  logic [2:0] tone;
  logic       piezo;
  logic       busy;
  logic       done;

  modport master (output trig, output tone, input piezo, input busy, input done);
  modport slave  (input trig, input tone, output piezo, output busy, output done);
endinterface

// File: rtl/tone_div.sv
// rtl/tone_div.sv - loadable half-period counter producing the square wave
module tone_div #(
  parameter int unsigned HP_W  = 11,
  parameter int unsigned CNT_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            restart,
  input  logic [HP_W-1:0] hp,
  output logic            sq
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;

  // restart wins over en so a retrigger always re-phases the wave high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      lim <= '0;
      sq  <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      lim <= CNT_W'(hp - HP_W'(1));
      sq  <= 1'b1;
    end else if (!en) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt == lim) begin
      cnt <= '0;
      sq  <= ~sq;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/beep_gen.sv
// rtl/beep_gen.sv - trigger-started fixed-length piezo tone burst with busy/done status
module beep_gen
  import beep_pkg::*;
#(
  parameter int unsigned CLK_HZ = 1_000_000,
  parameter int unsigned DUR_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  beep_gen_if.slave  bus
);

  localparam int unsigned DUR_CYC = CLK_HZ / 1000 * DUR_MS;
  localparam int unsigned DUR_W   = $clog2(DUR_CYC);
  localparam int unsigned HP_MAX  = hp_of(CLK_HZ, 0);
  localparam int unsigned CNT_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int unsigned HP_W    = $clog2(HP_MAX + 1);
  localparam int unsigned HP_TAB [8] = '{
    hp_of(CLK_HZ, 0), hp_of(CLK_HZ, 1), hp_of(CLK_HZ, 2), hp_of(CLK_HZ, 3),
    hp_of(CLK_HZ, 4), hp_of(CLK_HZ, 5), hp_of(CLK_HZ, 6), hp_of(CLK_HZ, 7)
  };

  state_t           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [2:0]       tone_q, tone_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             restart;
  logic [HP_W-1:0]  hp_sel;
  logic             sq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      tone_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // a trigger in either state restarts the burst, which is what suppresses done on the final cycle
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    done_d  = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.trig) begin
          state_d = PLAY;
          dur_d   = '0;
          tone_d  = bus.tone;
          restart = 1'b1;
        end
      end
      PLAY: begin
        if (bus.trig) begin
          dur_d   = '0;
          tone_d  = bus.tone;
          restart = 1'b1;
        end else if (dur_q == DUR_W'(DUR_CYC - 1)) begin
          state_d = IDLE;
          dur_d   = '0;
          done_d  = 1'b1;
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PLAY);
    hp_sel = HP_W'(HP_TAB[tone_d]);
  end

  tone_div #(
    .HP_W  (HP_W),
    .CNT_W (CNT_W)
  ) u_tone_div (
    .clk     (clk),
    .rst     (rst),
    .en      (busy_d),
    .restart (restart),
    .hp      (hp_sel),
    .sq      (sq)
  );

  assign bus.piezo = sq;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_beep_gen.sv
// tb/tb_beep_gen.sv - randomized scoreboard bench for beep_gen against a burst-timing model
module tb_beep_gen;

  localparam int CLK_HZ = 1_000_000;
  localparam int DUR_MS = 10;
  localparam int DUR    = CLK_HZ / 1000 * DUR_MS;
  localparam int NOTE [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

  logic clk = 1'b0;
  logic rst;

  beep_gen_if bus();

  beep_gen #(.CLK_HZ(CLK_HZ), .DUR_MS(DUR_MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] v;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   active = 1'b0;
  int   start  = 0;
  int   hp     = 1;

  function automatic int half_period(input int t);
    return CLK_HZ / (2 * NOTE[t]);
  endfunction

  // burst model: the latest accepted trigger at cycle s owns cycles s+1..s+DUR, done follows at s+DUR+1
  task automatic step(input logic t, input int tn, input logic r);
    exp_t       e;
    logic [2:0] tv;
    @(posedge clk);
    #1;
    tv       = (tn < 0) ? 3'($urandom) : 3'(tn);
    rst      = r;
    bus.trig = t;
    bus.tone = tv;
    e.cyc    = cyc;
    if (!r) begin
      e.v    = 3'b000;
      active = 1'b0;
    end else if (active && cyc <= start + DUR) begin
      e.v = {(((cyc - start - 1) / hp) % 2) == 0, 1'b1, 1'b0};
    end else if (active && cyc == start + DUR + 1) begin
      e.v    = 3'b001;
      active = 1'b0;
    end else begin
      e.v = 3'b000;
    end
    q.push_back(e);
    if (r && t) begin
      active = 1'b1;
      start  = cyc;
      hp     = half_period(int'(tv));
    end
    cyc++;
  endtask

  task automatic idle(input int n, input int tn);
    for (int i = 0; i < n; i++) step(1'b0, tn, 1'b1);
  endtask

  initial begin
    exp_t       e;
    logic [2:0] a, pe, pa;
    bit         first;
    first = 1'b1;
    pe    = 3'b000;
    pa    = 3'b000;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {bus.piezo, bus.busy, bus.done};
        if (first || e.v != pe || a != pa) begin
          n_cmp++;
          if (a !== e.v) begin
            n_bad++;
            $display("FAIL outputs cycle %0d: piezo/busy/done got %b required %b", e.cyc, a, e.v);
          end
        end
        first = 1'b0;
        pe    = e.v;
        pa    = a;
      end
    end
  end

  initial begin
    #50_000_000;
    n_bad++;
    $display("FAIL timeout: stimulus did not complete within the wait limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst      = 1'b0;
    bus.trig = 1'b0;
    bus.tone = 3'd0;

    for (int i = 0; i < 5; i++) step(1'($urandom), -1, 1'b0);

    @(negedge clk);
    n_cmp++;
    if ({bus.piezo, bus.busy, bus.done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset state: piezo/busy/done got %b required 000",
               {bus.piezo, bus.busy, bus.done});
    end

    idle(100, -1);
    step(1'b1, 5, 1'b1);
    idle(DUR + 20, -1);

    for (int t = 0; t < 8; t++) begin
      step(1'b1, t, 1'b1);
      if (t < 7) idle(2 * half_period(t) + int'($urandom_range(5, 200)), -1);
      else       idle(DUR + 20, -1);
    end

    step(1'b1, 0, 1'b1);
    idle(4999, -1);
    step(1'b1, 7, 1'b1);
    idle(DUR + 20, -1);

    step(1'b1, -1, 1'b1);
    idle(DUR - 1, -1);
    step(1'b1, -1, 1'b1);
    idle(DUR + 20, -1);

    step(1'b1, 2, 1'b1);
    idle(2999, -1);
    for (int i = 0; i < 5; i++) step(1'($urandom), -1, 1'b0);
    idle(50, -1);
    step(1'b1, 2, 1'b1);
    idle(499, 2);
    idle(DUR + 20, 6);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
